// File: rtl/wb_stage.sv
// Write-back stage: commits GPR/CSR writes, exceptions and ERTN, and tags
// interrupts onto the instruction entering the stage.
module wb_stage #(
  parameter logic [5:0]  ECODE_INT = 6'h00,
  parameter logic [31:0] COREID    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_rf_we,
  input  logic [4:0]  ms_rf_waddr,
  input  logic [31:0] ms_rf_wdata,
  input  logic        ms_csr_re,
  input  logic        ms_csr_we,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wmask,
  input  logic [31:0] ms_csr_wvalue,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic [31:0] ms_vaddr,
  input  logic        ms_ertn,
  input  logic        has_int,
  input  logic [31:0] csr_rvalue,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [31:0] wb_pc,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_vaddr,
  output logic [31:0] coreid_out,
  output logic        ws_flush,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [8:0] ESUB_ADEF  = 9'h000;

  // The slot state replaces the separate valid/ex/ertn flags; EXC wins over ERTN.
  typedef enum logic [1:0] {S_EMPTY, S_NORMAL, S_EXC, S_ERTN} state_t;
  state_t state, state_nxt;

  logic [31:0] pc_r, rf_wdata_r, csr_wmask_r, csr_wvalue_r, vaddr_r;
  logic [4:0]  rf_waddr_r;
  logic [13:0] csr_num_r;
  logic [5:0]  ecode_r;
  logic [8:0]  esubcode_r;
  logic        rf_we_r, csr_re_r, csr_we_r;
  logic        slot_valid, slot_ex, latch;

  always_comb begin
    ws_allowin = 1'b1;
    // Gating by reset keeps the reset cycle free of any commit side effects.
    slot_valid = (state != S_EMPTY) & ~reset;
    slot_ex    = slot_valid & (state == S_EXC);
    ws_flush   = slot_ex | (slot_valid & (state == S_ERTN));
    latch      = ms_valid & ws_allowin & ~ws_flush;
    state_nxt  = S_EMPTY;
    if (latch) begin
      if (has_int | ms_ex) state_nxt = S_EXC;
      else if (ms_ertn)    state_nxt = S_ERTN;
      else                 state_nxt = S_NORMAL;
    end

    wb_ex       = slot_ex;
    ertn_flush  = slot_valid & (state == S_ERTN);
    csr_we      = slot_valid & csr_we_r & ~slot_ex;
    csr_re      = slot_valid & csr_re_r;
    csr_num     = slot_valid ? csr_num_r    : '0;
    csr_wmask   = slot_valid ? csr_wmask_r  : '0;
    csr_wvalue  = slot_valid ? csr_wvalue_r : '0;
    wb_pc       = slot_valid ? pc_r         : '0;
    wb_ecode    = slot_valid ? ecode_r      : '0;
    wb_esubcode = slot_valid ? esubcode_r   : '0;
    wb_vaddr    = '0;
    if (slot_valid)
      wb_vaddr = (ecode_r == ECODE_ADE && esubcode_r == ESUB_ADEF) ? pc_r : vaddr_r;
    coreid_out  = COREID;
    rf_we       = slot_valid & rf_we_r & ~slot_ex;
    rf_waddr    = slot_valid ? rf_waddr_r : '0;
    rf_wdata    = '0;
    if (slot_valid) rf_wdata = csr_re_r ? csr_rvalue : rf_wdata_r;
    debug_wb_pc       = wb_pc;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_EMPTY;
      pc_r         <= '0;
      rf_we_r      <= 1'b0;
      rf_waddr_r   <= '0;
      rf_wdata_r   <= '0;
      csr_re_r     <= 1'b0;
      csr_we_r     <= 1'b0;
      csr_num_r    <= '0;
      csr_wmask_r  <= '0;
      csr_wvalue_r <= '0;
      ecode_r      <= '0;
      esubcode_r   <= '0;
      vaddr_r      <= '0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        pc_r         <= ms_pc;
        rf_we_r      <= ms_rf_we;
        rf_waddr_r   <= ms_rf_waddr;
        rf_wdata_r   <= ms_rf_wdata;
        csr_re_r     <= ms_csr_re;
        csr_we_r     <= ms_csr_we;
        csr_num_r    <= ms_csr_num;
        csr_wmask_r  <= ms_csr_wmask;
        csr_wvalue_r <= ms_csr_wvalue;
        ecode_r      <= has_int ? ECODE_INT : ms_ecode;
        esubcode_r   <= has_int ? 9'h000 : ms_esubcode;
        vaddr_r      <= ms_vaddr;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, GPR/CSR commit, exceptions, interrupt tagging, ERTN.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset, ms_valid, ms_rf_we, ms_csr_re, ms_csr_we, ms_ex, ms_ertn, has_int;
  logic [31:0] ms_pc, ms_rf_wdata, ms_csr_wmask, ms_csr_wvalue, ms_vaddr, csr_rvalue;
  logic [4:0]  ms_rf_waddr;
  logic [13:0] ms_csr_num;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic        ws_allowin, csr_re, csr_we, wb_ex, ertn_flush, ws_flush, rf_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, wb_pc, wb_vaddr, coreid_out, rf_wdata;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [3:0]  debug_wb_rf_we;
  int unsigned passed = 0, total = 0;

  always #5 clk = ~clk;

  wb_stage #(.ECODE_INT(6'h00), .COREID(32'h0)) dut (
    .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue), .ms_ex(ms_ex),
    .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode), .ms_vaddr(ms_vaddr), .ms_ertn(ms_ertn),
    .has_int(has_int), .csr_rvalue(csr_rvalue), .csr_re(csr_re), .csr_we(csr_we),
    .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
    .ertn_flush(ertn_flush), .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_vaddr(wb_vaddr), .coreid_out(coreid_out), .ws_flush(ws_flush), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clr_ms();
    ms_valid = 0; ms_pc = '0; ms_rf_we = 0; ms_rf_waddr = '0; ms_rf_wdata = '0;
    ms_csr_re = 0; ms_csr_we = 0; ms_csr_num = '0; ms_csr_wmask = '0; ms_csr_wvalue = '0;
    ms_ex = 0; ms_ecode = '0; ms_esubcode = '0; ms_vaddr = '0; ms_ertn = 0; has_int = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    clr_ms(); csr_rvalue = 32'h0; reset = 1;
    // 1: reset with a valid MEM instr pending
    ms_valid = 1; ms_pc = 32'h1c000000; ms_rf_we = 1; ms_rf_waddr = 5'd3; ms_rf_wdata = 32'h11;
    tick();
    chk("rst_allowin", ws_allowin, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_wb_ex", wb_ex, 0);
    chk("rst_flush", ws_flush, 0);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_pc", debug_wb_pc, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("coreid", coreid_out, 0);
    reset = 0;
    tick();
    chk("post_rst_rf_we", rf_we, 1);
    chk("post_rst_pc", debug_wb_pc, 32'h1c000000);
    chk("post_rst_waddr", rf_waddr, 3);

    // 2: load result
    ms_pc = 32'h1c000010; ms_rf_waddr = 5'd5; ms_rf_wdata = 32'hdeadbeef;
    tick();
    chk("ld_rf_we", rf_we, 1);
    chk("ld_dbg_we", debug_wb_rf_we, 4'hf);
    chk("ld_wdata", debug_wb_rf_wdata, 32'hdeadbeef);
    chk("ld_wnum", debug_wb_rf_wnum, 5);
    chk("ld_pc", wb_pc, 32'h1c000010);

    // 3: csrxchg returns old CSR value
    ms_pc = 32'h1c000014; ms_rf_waddr = 5'd6; ms_rf_wdata = 32'h0;
    ms_csr_re = 1; ms_csr_we = 1; ms_csr_num = 14'h30; ms_csr_wmask = 32'hff; ms_csr_wvalue = 32'h12;
    csr_rvalue = 32'h77;
    tick();
    chk("xchg_csr_we", csr_we, 1);
    chk("xchg_csr_re", csr_re, 1);
    chk("xchg_num", csr_num, 32'h30);
    chk("xchg_wmask", csr_wmask, 32'hff);
    chk("xchg_wvalue", csr_wvalue, 32'h12);
    chk("xchg_rf_wdata", rf_wdata, 32'h77);
    chk("xchg_rf_we", rf_we, 1);
    clr_ms();
    tick();
    chk("xchg_single_csr_we", csr_we, 0);
    chk("idle_rf_we", rf_we, 0);

    // 4: ALE exception, younger instr in MEM dropped
    ms_valid = 1; ms_pc = 32'h1c000020; ms_ex = 1; ms_ecode = 6'h09; ms_vaddr = 32'h1003;
    ms_rf_we = 1; ms_rf_waddr = 5'd7; ms_csr_we = 1;
    tick();
    chk("ale_wb_ex", wb_ex, 1);
    chk("ale_ecode", wb_ecode, 32'h09);
    chk("ale_vaddr", wb_vaddr, 32'h1003);
    chk("ale_rf_we", rf_we, 0);
    chk("ale_csr_we", csr_we, 0);
    chk("ale_flush", ws_flush, 1);
    chk("ale_pc", wb_pc, 32'h1c000020);
    clr_ms(); ms_valid = 1; ms_pc = 32'h1c000024; ms_rf_we = 1; ms_rf_waddr = 5'd8;
    tick();
    chk("ale_next_wb_ex", wb_ex, 0);
    chk("ale_dropped_rf_we", rf_we, 0);
    chk("ale_dropped_pc", debug_wb_pc, 0);
    chk("ale_next_flush", ws_flush, 0);
    tick();
    chk("ale_relatch_rf_we", rf_we, 1);
    chk("ale_relatch_pc", debug_wb_pc, 32'h1c000024);

    // ADEF: wb_vaddr comes from the PC
    clr_ms(); ms_valid = 1; ms_pc = 32'h1c000031; ms_ex = 1; ms_ecode = 6'h08;
    ms_esubcode = 9'h0; ms_vaddr = 32'h5555;
    tick();
    chk("adef_wb_ex", wb_ex, 1);
    chk("adef_vaddr", wb_vaddr, 32'h1c000031);
    clr_ms();
    tick();

    // 5: interrupt tagged on csrwr
    ms_valid = 1; ms_pc = 32'h1c000040; ms_csr_we = 1; ms_csr_num = 14'h5; has_int = 1;
    tick();
    chk("int_wb_ex", wb_ex, 1);
    chk("int_ecode", wb_ecode, 0);
    chk("int_csr_we", csr_we, 0);
    clr_ms();
    tick();
    // interrupt overrides ms_ertn and ms_ex codes
    ms_valid = 1; ms_pc = 32'h1c000044; ms_ertn = 1; ms_ex = 1; ms_ecode = 6'h0b;
    ms_esubcode = 9'h3; has_int = 1;
    tick();
    chk("int_ertn_wb_ex", wb_ex, 1);
    chk("int_ertn_flush", ertn_flush, 0);
    chk("int_ertn_ecode", wb_ecode, 0);
    chk("int_ertn_esub", wb_esubcode, 0);
    clr_ms();
    tick();

    // 6: ERTN single-cycle flush
    ms_valid = 1; ms_pc = 32'h1c000050; ms_ertn = 1;
    tick();
    chk("ertn_flush", ertn_flush, 1);
    chk("ertn_wb_ex", wb_ex, 0);
    chk("ertn_ws_flush", ws_flush, 1);
    clr_ms(); ms_valid = 1; ms_pc = 32'h1c000054; ms_rf_we = 1; ms_rf_waddr = 5'd9;
    tick();
    chk("ertn_pulse_end", ertn_flush, 0);
    chk("ertn_dropped_rf_we", rf_we, 0);
    tick();
    chk("ertn_relatch_rf_we", rf_we, 1);

    // reset mid-operation suppresses the commit in the reset cycle
    reset = 1; #1;
    chk("midrst_rf_we", rf_we, 0);
    clr_ms();
    tick();
    chk("midrst_pc", debug_wb_pc, 0);
    reset = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
